// File: rtl/qbus_pkg.sv
// -----------------------------------------------------------------------------
// qbus_pkg
// Shared definitions for the Qbus slave register file:
//   - qbus_slv_state_t : slave FSM state encoding
//   - IOPAGE_MSB       : highest address bit decoded inside the I/O page
//   - BDAL_W           : width of the multiplexed Qbus data/address lines
//   - clog2_regs()     : register-index width for a power-of-two register count
// -----------------------------------------------------------------------------
package qbus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        IGNORE   = 3'd2,
        WAIT_STB = 3'd3,
        RD_DRIVE = 3'd4,
        RD_RPLY  = 3'd5,
        WR_RPLY  = 3'd6,
        STB_END  = 3'd7
    } qbus_slv_state_t;

    localparam int IOPAGE_MSB = 12;
    localparam int BDAL_W     = 22;

    // Index width for n registers (n is a power of two, 2..64).
    function automatic int clog2_regs(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 7; k++) begin
            if ((32'sd1 << k) < n) begin
                r = k + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qbus_sync.sv
// -----------------------------------------------------------------------------
// qbus_sync
// Multi-flop synchroniser / alignment pipeline for asynchronous Qbus inputs.
// The same module is used for the strobes and for the data/address bundle so
// that both arrive at the FSM with identical latency.
// Ports:
//   clock  in      system clock
//   RSTN   in      synchronous active-low reset (stages load RST_VAL)
//   d_i    in  W   raw asynchronous inputs
//   q_o    out W   synchronised outputs, STAGES clocks later
// -----------------------------------------------------------------------------
module qbus_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; reset loads the inactive level so nothing looks asserted.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/qbus_regfile.sv
// -----------------------------------------------------------------------------
// qbus_regfile
// Single-clock Qbus slave register file: NREGS 16-bit registers in the I/O
// page, also readable/writable from a synchronous host port.
// Optional feature macro: QBUS_WRITE_IRQ_EN (per-register Qbus-write flags and
// host interrupt). Without it host_wflags and host_irq are tied low.
// Ports:
//   clock, RSTN            clock and synchronous active-low reset
//   BDALf_IN[21:0]         received BDAL (active-low)
//   BSYNCf BDINf BDOUTf    received bus control (active-low)
//   BWTBTf BBS7f BINITf
//   BDALf_OUT[21:0]        read data to the BDAL drivers
//   BDALf_OE[21:0]         BDAL driver enables
//   Outbound               BDAL transceiver direction/gate enable
//   BRPLYg                 reply gate drive (active-high)
//   host_addr/wdata/be     host register index, write data, byte enables
//   host_we/host_re        one-cycle host write / read strobes
//   host_rdata/rvalid      host read data, valid for one clock
//   host_wflags/host_irq   registers written from the Qbus side, and their OR
// -----------------------------------------------------------------------------
module qbus_regfile
    import qbus_pkg::*;
#(
    parameter logic [21:0] QADDR       = 22'o17772150,
    parameter int          NREGS       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          RPLY_DELAY  = 2,
    localparam int         AW          = clog2_regs(NREGS)
) (
    input  logic              clock,
    input  logic              RSTN,
    input  logic [BDAL_W-1:0] BDALf_IN,
    input  logic              BSYNCf,
    input  logic              BDINf,
    input  logic              BDOUTf,
    input  logic              BWTBTf,
    input  logic              BBS7f,
    input  logic              BINITf,
    output logic [BDAL_W-1:0] BDALf_OUT,
    output logic [BDAL_W-1:0] BDALf_OE,
    output logic              Outbound,
    output logic              BRPLYg,
    input  logic [AW-1:0]     host_addr,
    input  logic [15:0]       host_wdata,
    input  logic [1:0]        host_be,
    input  logic              host_we,
    input  logic              host_re,
    output logic [15:0]       host_rdata,
    output logic              host_rvalid,
    output logic [NREGS-1:0]  host_wflags,
    output logic              host_irq
);

    // ---------------- input synchronisation ----------------
    logic [3:0]        ctl_sync_s;
    logic [BDAL_W+1:0] dal_sync_s;
    logic              binit_s, bsync_s, din_s, dout_s, wtbt_s, bbs7_s;
    logic [BDAL_W-1:0] dal_s;
    logic              unused_s;

    qbus_sync #(
        .WIDTH   (4),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({4{1'b1}})
    ) u_sync_ctl (
        .clock (clock),
        .RSTN  (RSTN),
        .d_i   ({BINITf, BSYNCf, BDINf, BDOUTf}),
        .q_o   (ctl_sync_s)
    );

    qbus_sync #(
        .WIDTH   (BDAL_W + 2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({(BDAL_W + 2){1'b1}})
    ) u_sync_dal (
        .clock (clock),
        .RSTN  (RSTN),
        .d_i   ({BBS7f, BWTBTf, BDALf_IN}),
        .q_o   (dal_sync_s)
    );

    // Convert to active-high after sampling.
    assign binit_s = ~ctl_sync_s[3];
    assign bsync_s = ~ctl_sync_s[2];
    assign din_s   = ~ctl_sync_s[1];
    assign dout_s  = ~ctl_sync_s[0];
    assign bbs7_s  = ~dal_sync_s[BDAL_W+1];
    assign wtbt_s  = ~dal_sync_s[BDAL_W];
    assign dal_s   = ~dal_sync_s[BDAL_W-1:0];

    // Upper BDAL bits carry neither page-local address nor data.
    assign unused_s = ^dal_s[BDAL_W-1:16];

    // ---------------- state and registers ----------------
    qbus_slv_state_t   state_q;
    logic [IOPAGE_MSB:0] addr_q;
    logic              bbs7_q;
    logic [3:0]        cnt_q;
    logic              brply_q, outb_q;
    logic [BDAL_W-1:0] oe_q, bdal_out_q;
    logic [15:0]       regs_q [NREGS];
    logic [15:0]       regs_d [NREGS];
    logic [15:0]       host_rdata_q;
    logic              host_rvalid_q;

    logic [AW-1:0]     idx_s;
    logic              byte_s;
    logic              sel_s;
    logic              qwr_en_s;
    logic [1:0]        qwr_be_s;

    assign idx_s  = addr_q[AW:1];
    assign byte_s = addr_q[0];
    assign sel_s  = bbs7_q && (addr_q[IOPAGE_MSB:AW+1] == QADDR[IOPAGE_MSB:AW+1]);

    // Qbus write strobe: matches the WAIT_STB -> WR_RPLY transition below.
    always_comb begin
        qwr_en_s = 1'b0;
        qwr_be_s = 2'b00;
        if ((state_q == WAIT_STB) && bsync_s && !binit_s && dout_s && !din_s) begin
            qwr_en_s = 1'b1;
            if (wtbt_s) begin
                // Byte write: odd address is the high byte on BDAL[15:8].
                qwr_be_s = byte_s ? 2'b10 : 2'b01;
            end else begin
                qwr_be_s = 2'b11;
            end
        end else begin
            qwr_en_s = 1'b0;
            qwr_be_s = 2'b00;
        end
    end

    // Register next state: per byte, a Qbus write beats a host write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int b = 0; b < 2; b++) begin
                if (qwr_en_s && qwr_be_s[b] && (idx_s == AW'(i))) begin
                    regs_d[i][b*8 +: 8] = dal_s[b*8 +: 8];
                end else if (host_we && host_be[b] && (host_addr == AW'(i))) begin
                    regs_d[i][b*8 +: 8] = host_wdata[b*8 +: 8];
                end else begin
                    regs_d[i][b*8 +: 8] = regs_q[i][b*8 +: 8];
                end
            end
        end
    end

    // Register array storage; survives BINIT, cleared only by RSTN.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Host read port: data and valid one clock after host_re.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            host_rdata_q  <= 16'h0000;
            host_rvalid_q <= 1'b0;
        end else begin
            host_rvalid_q <= host_re;
            if (host_re) begin
                host_rdata_q <= regs_q[host_addr];
            end
        end
    end

    // Slave FSM with registered reply and driver controls.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            addr_q     <= {(IOPAGE_MSB + 1){1'b0}};
            bbs7_q     <= 1'b0;
            cnt_q      <= 4'd0;
            brply_q    <= 1'b0;
            outb_q     <= 1'b0;
            oe_q       <= {BDAL_W{1'b0}};
            bdal_out_q <= {BDAL_W{1'b0}};
        end else if (binit_s || !bsync_s) begin
            // Bus init or end of cycle: release everything at once.
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            brply_q    <= 1'b0;
            outb_q     <= 1'b0;
            oe_q       <= {BDAL_W{1'b0}};
            bdal_out_q <= {BDAL_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q  <= dal_s[IOPAGE_MSB:0];
                    bbs7_q  <= bbs7_s;
                    state_q <= DECODE;
                end
                DECODE: begin
                    state_q <= sel_s ? WAIT_STB : IGNORE;
                end
                IGNORE: begin
                    state_q <= IGNORE;
                end
                WAIT_STB: begin
                    if (din_s) begin
                        bdal_out_q <= {6'b000000, regs_q[idx_s]};
                        oe_q       <= {BDAL_W{1'b1}};
                        outb_q     <= 1'b1;
                        cnt_q      <= 4'd1;
                        state_q    <= RD_DRIVE;
                    end else if (dout_s) begin
                        state_q <= WR_RPLY;
                    end else begin
                        state_q <= WAIT_STB;
                    end
                end
                RD_DRIVE: begin
                    if (!din_s) begin
                        oe_q       <= {BDAL_W{1'b0}};
                        outb_q     <= 1'b0;
                        bdal_out_q <= {BDAL_W{1'b0}};
                        state_q    <= STB_END;
                    end else if (cnt_q == 4'(RPLY_DELAY)) begin
                        brply_q <= 1'b1;
                        state_q <= RD_RPLY;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RD_RPLY: begin
                    if (!din_s) begin
                        brply_q    <= 1'b0;
                        oe_q       <= {BDAL_W{1'b0}};
                        outb_q     <= 1'b0;
                        bdal_out_q <= {BDAL_W{1'b0}};
                        state_q    <= STB_END;
                    end else begin
                        brply_q <= 1'b1;
                    end
                end
                WR_RPLY: begin
                    if (!dout_s) begin
                        brply_q <= 1'b0;
                        state_q <= STB_END;
                    end else begin
                        brply_q <= 1'b1;
                    end
                end
                STB_END: begin
                    // BSYNC still held: read-modify-write continues.
                    state_q <= WAIT_STB;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BDALf_OUT   = bdal_out_q;
    assign BDALf_OE    = oe_q;
    assign Outbound    = outb_q;
    assign BRPLYg      = brply_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

`ifdef QBUS_WRITE_IRQ_EN
    logic [NREGS-1:0] wflags_q, wflags_d;
    logic             qset_q, hclr_q, irq_q;
    logic [AW-1:0]    qset_idx_q, hclr_idx_q;

    // Delay set and clear events by one clock so a same-cycle collision resolves together.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            qset_q     <= 1'b0;
            qset_idx_q <= {AW{1'b0}};
            hclr_q     <= 1'b0;
            hclr_idx_q <= {AW{1'b0}};
        end else begin
            qset_q     <= qwr_en_s;
            qset_idx_q <= idx_s;
            hclr_q     <= host_we;
            hclr_idx_q <= host_addr;
        end
    end

    // Flag next state: BINIT clears, host clear beats Qbus set.
    always_comb begin
        wflags_d = wflags_q;
        if (binit_s) begin
            wflags_d = {NREGS{1'b0}};
        end else begin
            if (qset_q) begin
                wflags_d[qset_idx_q] = 1'b1;
            end else begin
                wflags_d = wflags_d;
            end
            if (hclr_q) begin
                wflags_d[hclr_idx_q] = 1'b0;
            end else begin
                wflags_d = wflags_d;
            end
        end
    end

    // Flag and interrupt registers.
    always_ff @(posedge clock) begin
        if (!RSTN) begin
            wflags_q <= {NREGS{1'b0}};
            irq_q    <= 1'b0;
        end else begin
            wflags_q <= wflags_d;
            irq_q    <= |wflags_d;
        end
    end

    assign host_wflags = wflags_q;
    assign host_irq    = irq_q;
`else
    assign host_wflags = {NREGS{1'b0}};
    assign host_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_qbus_regfile.sv
// -----------------------------------------------------------------------------
// tb_qbus_regfile
// Directed pin-level bench for qbus_regfile (NREGS=4, SYNC_STAGES=2,
// RPLY_DELAY=2). Expected read data is queued when a read is launched and
// popped when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_qbus_regfile;

    localparam int SYNC = 2;
    localparam int RPLY = 2;

    logic        clock = 1'b0;
    logic        RSTN;
    logic [21:0] BDALf_IN;
    logic        BSYNCf, BDINf, BDOUTf, BWTBTf, BBS7f, BINITf;
    logic [21:0] BDALf_OUT, BDALf_OE;
    logic        Outbound, BRPLYg;
    logic [1:0]  host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_be;
    logic        host_we, host_re;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic [3:0]  host_wflags;
    logic        host_irq;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    int          n_rply  = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  exp_flag2;

    always #10 clock = ~clock;

    qbus_regfile #(
        .QADDR       (22'o17772150),
        .NREGS       (4),
        .SYNC_STAGES (SYNC),
        .RPLY_DELAY  (RPLY)
    ) dut (
        .clock       (clock),
        .RSTN        (RSTN),
        .BDALf_IN    (BDALf_IN),
        .BSYNCf      (BSYNCf),
        .BDINf       (BDINf),
        .BDOUTf      (BDOUTf),
        .BWTBTf      (BWTBTf),
        .BBS7f       (BBS7f),
        .BINITf      (BINITf),
        .BDALf_OUT   (BDALf_OUT),
        .BDALf_OE    (BDALf_OE),
        .Outbound    (Outbound),
        .BRPLYg      (BRPLYg),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_be     (host_be),
        .host_we     (host_we),
        .host_re     (host_re),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_wflags (host_wflags),
        .host_irq    (host_irq)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bus_begin(input logic [21:0] addr, input logic bs7);
        BDALf_IN = ~addr;
        BBS7f    = ~bs7;
        tick();
        BSYNCf = 1'b0;
        repeat (5) tick();
        BBS7f    = 1'b1;
        BDALf_IN = {22{1'b1}};
    endtask

    task automatic bus_end();
        BSYNCf = 1'b1;
        repeat (4) tick();
    endtask

    task automatic host_write(input logic [1:0] idx, input logic [15:0] data, input logic [1:0] be);
        host_addr  = idx;
        host_wdata = data;
        host_be    = be;
        host_we    = 1'b1;
        tick();
        host_we = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [1:0] idx, input logic [15:0] expv);
        exp_q.push_back(32'(expv));
        host_addr = idx;
        host_re   = 1'b1;
        tick();
        host_re = 1'b0;
        check({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
        check(tag, 32'(host_rdata), exp_q.pop_front());
        tick();
        check({tag, "_rvalid_drop"}, 32'(host_rvalid), 32'd0);
    endtask

    // Data phase of a write; optionally a host write lands on the Qbus write clock.
    task automatic bus_write(input string tag, input logic [15:0] data, input logic byte_op,
                             input logic hcol, input logic [1:0] hidx,
                             input logic [15:0] hdata, input logic [1:0] hbe);
        int cyc;
        BDALf_IN = ~{6'b000000, data};
        BWTBTf   = ~byte_op;
        tick();
        BDOUTf = 1'b0;
        cyc = 0;
        while (BRPLYg !== 1'b1 && cyc < 20) begin
            if (hcol && cyc == 2) begin
                host_addr  = hidx;
                host_wdata = hdata;
                host_be    = hbe;
                host_we    = 1'b1;
            end
            tick();
            cyc++;
            if (cyc == 3) host_we = 1'b0;
        end
        if (BRPLYg === 1'b1) n_rply++;
        check({tag, "_rply_lat"}, 32'(cyc), 32'(SYNC + 2));
        BDOUTf = 1'b1;
        cyc = 0;
        while (BRPLYg !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_release_lat"}, 32'(cyc), 32'(SYNC + 1));
        BWTBTf   = 1'b1;
        BDALf_IN = {22{1'b1}};
    endtask

    task automatic bus_read(input string tag, input logic [21:0] expv);
        int cyc;
        exp_q.push_back(32'(expv));
        BDINf = 1'b0;
        cyc = 0;
        while (BDALf_OE !== {22{1'b1}} && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_drive_lat"}, 32'(cyc), 32'(SYNC + 1));
        check({tag, "_outb_before_rply"}, 32'({Outbound, BRPLYg}), 32'b10);
        cyc = 0;
        while (BRPLYg !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        if (BRPLYg === 1'b1) n_rply++;
        check({tag, "_rply_delay"}, 32'(cyc), 32'(RPLY));
        check({tag, "_data"}, 32'(BDALf_OUT), exp_q.pop_front());
        BDINf = 1'b1;
        cyc = 0;
        while (BRPLYg !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_release_lat"}, 32'(cyc), 32'(SYNC + 1));
        check({tag, "_drivers_off"}, 32'({BDALf_OE, Outbound}), 32'd0);
    endtask

    // Read attempt that must not be answered.
    task automatic bus_read_none(input string tag);
        logic seen;
        seen  = 1'b0;
        BDINf = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | BRPLYg | Outbound | (|BDALf_OE);
        end
        BDINf = 1'b1;
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic wait_rply(input string tag);
        int cyc;
        cyc = 0;
        while (BRPLYg !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check(tag, 32'(BRPLYg), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef QBUS_WRITE_IRQ_EN
        exp_flag2 = 4'b0100;
`else
        exp_flag2 = 4'b0000;
`endif
        RSTN       = 1'b0;
        BDALf_IN   = {22{1'b1}};
        BSYNCf     = 1'b1;
        BDINf      = 1'b1;
        BDOUTf     = 1'b1;
        BWTBTf     = 1'b1;
        BBS7f      = 1'b1;
        BINITf     = 1'b1;
        host_addr  = 2'd0;
        host_wdata = 16'h0000;
        host_be    = 2'b00;
        host_we    = 1'b0;
        host_re    = 1'b0;
        repeat (4) tick();
        check("rst_outputs", 32'({BRPLYg, Outbound, host_rvalid, host_irq}), 32'd0);
        check("rst_oe", 32'(BDALf_OE), 32'd0);
        check("rst_wflags", 32'(host_wflags), 32'd0);
        RSTN = 1'b1;
        repeat (3) tick();
        host_read("rst_reg0", 2'd0, 16'h0000);

        // DATO word to index 1
        bus_begin(22'o17772152, 1'b1);
        bus_write("dato", 16'h1234, 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00);
        bus_end();
        host_read("dato_reg1", 2'd1, 16'h1234);

        // DATOB to odd and even byte of index 2
        host_write(2'd2, 16'h5566, 2'b11);
        bus_begin(22'o17772155, 1'b1);
        bus_write("datob_hi", 16'hABAB, 1'b1, 1'b0, 2'd0, 16'h0000, 2'b00);
        bus_end();
        host_read("datob_hi_reg2", 2'd2, 16'hAB66);
        bus_begin(22'o17772154, 1'b1);
        bus_write("datob_lo", 16'h55CC, 1'b1, 1'b0, 2'd0, 16'h0000, 2'b00);
        bus_end();
        host_read("datob_lo_reg2", 2'd2, 16'hABCC);

        // DATI from index 0
        host_write(2'd0, 16'hBEEF, 2'b11);
        bus_begin(22'o17772150, 1'b1);
        bus_read("dati", 22'h00BEEF);
        bus_end();

        // DATIO on index 3: two replies inside one BSYNC
        host_write(2'd3, 16'h7777, 2'b11);
        n_rply = 0;
        bus_begin(22'o17772156, 1'b1);
        bus_read("datio_rd", 22'h007777);
        bus_write("datio_wr", 16'h0F0F, 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00);
        bus_end();
        check("datio_replies", 32'(n_rply), 32'd2);
        host_read("datio_reg3", 2'd3, 16'h0F0F);

        // Not selected: outside the block, and BBS7 negated
        bus_begin(22'o17772160, 1'b1);
        bus_read_none("nosel_addr");
        bus_end();
        bus_begin(22'o17772150, 1'b0);
        bus_read_none("nosel_bbs7");
        bus_end();

        // Host/Qbus collisions on index 1
        bus_begin(22'o17772152, 1'b1);
        bus_write("col_word", 16'hAAAA, 1'b0, 1'b1, 2'd1, 16'h5555, 2'b11);
        bus_end();
        host_read("col_word_reg1", 2'd1, 16'hAAAA);
        bus_begin(22'o17772153, 1'b1);
        bus_write("col_byte", 16'hC3C3, 1'b1, 1'b1, 2'd1, 16'h0011, 2'b01);
        bus_end();
        host_read("col_byte_reg1", 2'd1, 16'hC311);

        // BINIT during a read
        bus_begin(22'o17772150, 1'b1);
        BDINf = 1'b0;
        wait_rply("binit_rply_seen");
        BINITf = 1'b0;
        repeat (SYNC + 1) tick();
        check("binit_drivers_off", 32'({BRPLYg, Outbound, (|BDALf_OE)}), 32'd0);
        BDINf  = 1'b1;
        BSYNCf = 1'b1;
        repeat (4) tick();
        check("binit_wflags", 32'({host_irq, host_wflags}), 32'd0);
        BINITf = 1'b1;
        repeat (4) tick();
        host_read("binit_reg0", 2'd0, 16'hBEEF);

        // Write-notify flags
        bus_begin(22'o17772154, 1'b1);
        bus_write("flag_wr", 16'h2222, 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00);
        bus_end();
        check("flag_set", 32'(host_wflags), 32'(exp_flag2));
        check("flag_irq", 32'(host_irq), 32'(|exp_flag2));
        host_write(2'd2, 16'h0000, 2'b00);
        repeat (2) tick();
        check("flag_host_clear", 32'({host_irq, host_wflags}), 32'd0);
        bus_begin(22'o17772154, 1'b1);
        bus_write("flag_col", 16'h3333, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00);
        bus_end();
        check("flag_col_clear", 32'({host_irq, host_wflags}), 32'd0);
        host_read("flag_col_reg2", 2'd2, 16'h3333);

        // Reset in the middle of a read
        bus_begin(22'o17772150, 1'b1);
        BDINf = 1'b0;
        wait_rply("mrst_rply_seen");
        RSTN = 1'b0;
        tick();
        check("mrst_release", 32'({BRPLYg, Outbound, (|BDALf_OE)}), 32'd0);
        BDINf  = 1'b1;
        BSYNCf = 1'b1;
        repeat (3) tick();
        RSTN = 1'b1;
        repeat (3) tick();
        host_read("mrst_reg0", 2'd0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
